// File: rtl/button_debounce.sv
// button_debounce: synchronises, debounces and edge-detects up to WIDTH raw
// push-button inputs on the clk50 domain, and keeps a wrapping press counter.
//
// Ports
//   clk50        in   1      system clock, all logic on posedge
//   rst          in   1      synchronous reset, active-high
//   btn_raw      in   WIDTH  asynchronous raw button pins
//   btn_state    out  WIDTH  debounced level, 1 = pressed
//   btn_press    out  WIDTH  1-cycle pulse on debounced 0->1 transition
//   btn_release  out  WIDTH  1-cycle pulse on debounced 1->0 transition
//   press_count  out  8      total debounced presses over all channels, mod 256
module button_debounce #(
    parameter int unsigned WIDTH         = 6,
    parameter int unsigned STABLE_CYCLES = 500000,
    parameter int unsigned ACTIVE_LOW    = 0
) (
    input  logic             clk50,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_state,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release,
    output logic [7:0]       press_count
);

    localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] INV_MASK = (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        IDLE_LO   = 2'd0,
        SETTLE_HI = 2'd1,
        IDLE_HI   = 2'd2,
        SETTLE_LO = 2'd3
    } deb_state_t;

    logic [WIDTH-1:0] sync_s1;
    logic [WIDTH-1:0] sync_s2;

    deb_state_t       state_q [WIDTH];
    deb_state_t       state_d [WIDTH];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];

    logic [WIDTH-1:0] level_d;
    logic [WIDTH-1:0] press_d;
    logic [WIDTH-1:0] release_d;
    logic [7:0]       count_d;

    // Polarity normalisation followed by a 2-flop synchroniser per bit.
    always_ff @(posedge clk50) begin
        if (rst) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= btn_raw ^ INV_MASK;
            sync_s2 <= sync_s1;
        end
    end

    // Per-channel debounce FSM: a level must differ from btn_state for
    // STABLE_CYCLES consecutive cycles before it is committed.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            level_d[i]   = btn_state[i];
            press_d[i]   = 1'b0;
            release_d[i] = 1'b0;

            case (state_q[i])
                IDLE_LO, SETTLE_HI: begin
                    if (!sync_s2[i]) begin
                        // Matches committed level: any partial settle is lost.
                        state_d[i] = IDLE_LO;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = IDLE_HI;
                        cnt_d[i]   = '0;
                        level_d[i] = 1'b1;
                        press_d[i] = 1'b1;
                    end else begin
                        state_d[i] = SETTLE_HI;
                        cnt_d[i]   = cnt_q[i] + CNT_W'(1);
                    end
                end
                IDLE_HI, SETTLE_LO: begin
                    if (sync_s2[i]) begin
                        state_d[i] = IDLE_HI;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i]   = IDLE_LO;
                        cnt_d[i]     = '0;
                        level_d[i]   = 1'b0;
                        release_d[i] = 1'b1;
                    end else begin
                        state_d[i] = SETTLE_LO;
                        cnt_d[i]   = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = IDLE_LO;
                    cnt_d[i]   = '0;
                    level_d[i] = 1'b0;
                end
            endcase
        end
    end

    // Same-edge presses on several channels are summed into one update.
    always_comb begin
        count_d = press_count;
        for (int i = 0; i < WIDTH; i++) begin
            count_d = count_d + 8'(press_d[i]);
        end
    end

    // State, counters and all outputs registered together.
    always_ff @(posedge clk50) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= IDLE_LO;
                cnt_q[i]   <= '0;
            end
            btn_state   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            press_count <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            btn_state   <= level_d;
            btn_press   <= press_d;
            btn_release <= release_d;
            press_count <= count_d;
        end
    end

endmodule
